keypad_reader: RTL and testbench
================================

Name: keypad_reader

Overview:
- Bus-slave input peripheral: the reading side of the bus, complementing the 7-segment display writer.
- Scans a 4x4 matrix keypad and debounces single-key presses.
- Queues key codes in a small FIFO; the CPU pops them over the WB-style slave interface (same select/we/ack handshake as the display peripheral).
- Sits on the peripheral bus next to the display block.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven before rows are sampled (>=4)
DEBOUNCE_CNT, 4, consecutive identical scan frames required to accept a press or release (1..15)
FIFO_DEPTH, 4, key-code FIFO entries (power of two, 2..16)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
bus_addr_i  input  32  byte address; only [3:2] decoded
bus_data_i  input  32  write data
bus_data_o  output  32  read data
bus_select_i  input  1  slave select
bus_we_i  input  1  1=write, 0=read
bus_ack_o  output  1  single-cycle transfer acknowledge
col_o  output  4  column drive, active-low one-hot
row_i  input  4  row sense, active-low, asynchronous to clk
irq_o  output  1  high while FIFO non-empty

Behaviour:
- Reset (rst=0, async):
  - col_o=4'b1110; bus_ack_o=0; bus_data_o=0; irq_o=0.
  - FIFO empty, overflow flag 0, debouncer in RELEASED, all counters 0.
- Row input: row_i passes through a 2-flop synchronizer before any use.
- Scan:
  - Column c (0..3) is driven low for SCAN_DIV cycles.
  - Synchronized rows are sampled on the last cycle of each window; col_o then advances c -> c+1 mod 4.
  - A frame is 4 windows and ends at column 3's sample.
- Frame result:
  - Exactly one key down: VALID with code = {col[1:0], row[1:0]}, where row = index of the low bit.
  - No key down: NONE.
  - More than one key down (ghosting): MULTI.
- Debouncer FSM (evaluated once per frame end; cnt is 4 bits):
  - RELEASED: VALID -> PRESS_CAND, latch code, cnt=1. Otherwise stay.
  - PRESS_CAND: VALID with same code -> cnt+1. VALID with a different code -> relatch, cnt=1. NONE -> RELEASED. MULTI -> hold (cnt unchanged). When cnt reaches DEBOUNCE_CNT -> push code, go to HELD.
  - HELD: NONE -> RELEASE_CAND, cnt=1. VALID/MULTI -> stay.
  - RELEASE_CAND: NONE -> cnt+1. Anything else -> HELD. When cnt reaches DEBOUNCE_CNT -> RELEASED.
  - With DEBOUNCE_CNT=1, the push happens on the same frame that enters PRESS_CAND, and release is immediate likewise.
  - Exactly one push per debounced press; holding a key never repeats.
- FIFO:
  - Push while full: code dropped, overflow flag set (sticky).
  - Push and pop in the same cycle when full: both succeed and count is unchanged.
  - Push and pop in the same cycle when empty: the pop reads empty, the push is stored.
- Register map (addr[3:2]):
  - 0 DATA, read: {23'b0, valid, 4'b0, code[3:0]}, where valid=1 if the FIFO was non-empty. Pops one entry. Read when empty returns 0 and does not pop.
  - 1 STATUS, read: {24'b0, overflow, full, empty, count[4:0]}. No side effects.
  - 2 CTRL, write: bit0=1 flushes the FIFO; bit1=1 clears overflow. Reads return 0.
  - 3 reserved: reads return 0, writes are ignored, still acked.
  - Writes to 0/1 are acked with no effect.
- Handshake:
  - On the first cycle bus_select_i=1 with bus_ack_o=0, the slave registers the access.
  - bus_ack_o=1 on the next cycle, for exactly one cycle; bus_data_o is valid on that same cycle.
  - Side effects (pop, flush, clear) take effect on the ack cycle.
  - bus_ack_o is then 0 for at least one cycle even if select stays high; a held select produces a new access every 2 cycles.
  - bus_data_o returns to 0 when not acking.
- irq_o = registered !empty, updated the cycle after the FIFO changes.
- Reset mid-scan or mid-transfer: immediate return to reset values; a pending ack is discarded.

Test Plan:
- SCAN_DIV=4, DEBOUNCE_CNT=2: hold row1 low only while col2 is low for 3 frames -> exactly one push of code 4'h9; irq_o rises; DATA read returns 32'h0000_0109 and irq_o falls.
- Key 0x5 pressed 1 frame, released 2 frames -> no push; STATUS reads 32'h0000_0020 (empty=1, count=0).
- Rows 0 and 1 both low on col0 for 5 frames after a PRESS_CAND on code 0x0 -> FSM holds, no push until the MULTI frames end and a VALID frame completes the count.
- FIFO_DEPTH=4: 5 distinct debounced presses with no reads -> STATUS 32'h0000_00C4; CTRL write 32'h2 -> 32'h0000_0044; then four DATA reads return codes in press order; a fifth read returns 0.
- bus_select_i held high for 6 cycles on DATA with 2 entries queued -> acks on cycles 2, 4, 6; data = entry0, entry1, then 0.
- rst pulsed low mid-window with 3 entries queued -> col_o=4'b1110, FIFO empty, irq_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/keypad_reader.sv
// 4x4 matrix keypad scanner with frame-based debounce, key-code FIFO
// and a select/we/ack bus slave for popping codes and reading status.
module keypad_reader #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr_i,
    input  logic [31:0] bus_data_i,
    output logic [31:0] bus_data_o,
    input  logic        bus_select_i,
    input  logic        bus_we_i,
    output logic        bus_ack_o,
    output logic [3:0]  col_o,
    input  logic [3:0]  row_i,
    output logic        irq_o
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        RELEASED, PRESS_CAND, HELD, RELEASE_CAND
    } db_state_t;

    typedef enum logic [1:0] {
        F_NONE, F_VALID, F_MULTI
    } frame_t;

    logic [3:0]    row_s1, row_s2;
    logic [DW-1:0] div;
    logic [1:0]    col;
    logic          sample, frame_end;

    assign sample    = (div == DW'(SCAN_DIV - 1));
    assign frame_end = sample && (col == 2'd3);
    assign col_o     = ~(4'b0001 << col);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
            div    <= '0;
            col    <= 2'd0;
        end else begin
            row_s1 <= row_i;
            row_s2 <= row_s1;
            if (sample) begin
                div <= '0;
                col <= col + 2'd1;
            end else begin
                div <= div + DW'(1);
            end
        end
    end

    logic [3:0] down;
    logic [1:0] win_row;
    logic       win_one, win_multi;

    assign down      = ~row_s2;
    assign win_multi = (down & (down - 4'd1)) != 4'd0;
    assign win_one   = (down != 4'd0) && !win_multi;

    always_comb begin
        win_row = 2'd0;
        if (down[0])      win_row = 2'd0;
        else if (down[1]) win_row = 2'd1;
        else if (down[2]) win_row = 2'd2;
        else if (down[3]) win_row = 2'd3;
    end

    // Per-frame accumulation: a second single-key window also makes it MULTI.
    logic       acc_any, acc_multi;
    logic [3:0] acc_code;
    logic       f_any, f_multi;
    logic [3:0] f_code;
    frame_t     fres;

    assign f_multi = acc_multi | win_multi | (acc_any & win_one);
    assign f_any   = acc_any | win_one;
    assign f_code  = acc_any ? acc_code : {col, win_row};
    assign fres    = f_multi ? F_MULTI : (f_any ? F_VALID : F_NONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_any   <= 1'b0;
            acc_multi <= 1'b0;
            acc_code  <= 4'd0;
        end else if (sample) begin
            acc_any   <= frame_end ? 1'b0 : f_any;
            acc_multi <= frame_end ? 1'b0 : f_multi;
            acc_code  <= frame_end ? 4'd0 : f_code;
        end
    end

    db_state_t  state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [3:0] dcode, dcode_n;
    logic       push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RELEASED;
            cnt   <= 4'd0;
            dcode <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            dcode <= dcode_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dcode_n = dcode;
        push    = 1'b0;
        if (frame_end) begin
            unique case (state)
                RELEASED: if (fres == F_VALID) begin
                    dcode_n = f_code;
                    cnt_n   = 4'd1;
                    state_n = PRESS_CAND;
                end
                PRESS_CAND: begin
                    if (fres == F_NONE) begin
                        state_n = RELEASED;
                    end else if (fres == F_VALID) begin
                        if (f_code == dcode) begin
                            cnt_n = cnt + 4'd1;
                        end else begin
                            dcode_n = f_code;
                            cnt_n   = 4'd1;
                        end
                    end
                end
                HELD: if (fres == F_NONE) begin
                    cnt_n   = 4'd1;
                    state_n = RELEASE_CAND;
                end
                RELEASE_CAND: begin
                    if (fres == F_NONE) cnt_n = cnt + 4'd1;
                    else                state_n = HELD;
                end
            endcase
            if (state_n == PRESS_CAND && fres == F_VALID &&
                cnt_n >= 4'(DEBOUNCE_CNT)) begin
                push    = 1'b1;
                state_n = HELD;
            end
            if (state_n == RELEASE_CAND && cnt_n >= 4'(DEBOUNCE_CNT))
                state_n = RELEASED;
        end
    end

    logic          ack;
    logic [1:0]    acc_addr;
    logic          acc_we;
    logic [1:0]    acc_wd;
    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    count;
    logic          ovf, empty, full;
    logic          pop, flush, clr_ovf, push_ok;
    logic [31:0]   rdata;
    logic          unused;

    assign unused  = ^{bus_addr_i[31:4], bus_addr_i[1:0], bus_data_i[31:2]};
    assign empty   = (count == 5'd0);
    assign full    = (count == 5'(FIFO_DEPTH));
    assign pop     = ack && !acc_we && acc_addr == 2'd0 && !empty;
    assign flush   = ack && acc_we && acc_addr == 2'd2 && acc_wd[0];
    assign clr_ovf = ack && acc_we && acc_addr == 2'd2 && acc_wd[1];
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= dcode_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack      <= 1'b0;
            acc_addr <= 2'd0;
            acc_we   <= 1'b0;
            acc_wd   <= 2'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 5'd0;
            ovf      <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            ack <= bus_select_i && !ack;
            if (bus_select_i && !ack) begin
                acc_addr <= bus_addr_i[3:2];
                acc_we   <= bus_we_i;
                acc_wd   <= bus_data_i[1:0];
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= 5'd0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop)     rd_ptr <= rd_ptr + AW'(1);
                count <= count + 5'(push_ok) - 5'(pop);
            end
            // Set wins over a simultaneous clear so no drop goes unreported.
            if (push && full && !pop) ovf <= 1'b1;
            else if (clr_ovf)         ovf <= 1'b0;
            irq_o <= !empty;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (!acc_we) begin
            unique case (acc_addr)
                2'd0: if (!empty) rdata = {23'd0, 1'b1, 4'd0, mem[rd_ptr]};
                2'd1: rdata = {24'd0, ovf, full, empty, count};
                default: rdata = 32'd0;
            endcase
        end
    end

    assign bus_ack_o  = ack;
    assign bus_data_o = ack ? rdata : 32'd0;

endmodule

// File: tb/tb_keypad_reader.sv
// Scoreboard bench for keypad_reader: an electrical keypad model feeds
// rows from col_o, and debounced codes are checked as the CPU pops them.
module tb_keypad_reader;

    localparam int SD    = 4;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] bus_addr_i = '0;
    logic [31:0] bus_data_i = '0;
    logic [31:0] bus_data_o;
    logic        bus_select_i = 1'b0;
    logic        bus_we_i = 1'b0;
    logic        bus_ack_o;
    logic [3:0]  col_o;
    logic [3:0]  row_i;
    logic        irq_o;

    logic [15:0] keys = '0;
    logic [3:0]  exp_q [$];
    int          total = 0;
    int          bad = 0;

    keypad_reader #(
        .SCAN_DIV(SD), .DEBOUNCE_CNT(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .bus_addr_i(bus_addr_i), .bus_data_i(bus_data_i),
        .bus_data_o(bus_data_o), .bus_select_i(bus_select_i),
        .bus_we_i(bus_we_i), .bus_ack_o(bus_ack_o),
        .col_o(col_o), .row_i(row_i), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    // Key index c*4+r shorts column c to row r.
    always_comb begin
        row_i = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!col_o[c])
                for (int r = 0; r < 4; r++)
                    if (keys[c*4+r]) row_i[r] = 1'b0;
    end

    function automatic logic [31:0] model_pop();
        if (exp_q.size() == 0) return 32'd0;
        return {23'd0, 1'b1, 4'd0, exp_q.pop_front()};
    endfunction

    task automatic wait_frame_start();
        logic [3:0] prev;
        bit         seen;
        prev = col_o;
        seen = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(posedge clk); #1;
            if (prev == 4'b0111 && col_o == 4'b1110) begin
                seen = 1;
                break;
            end
            prev = col_o;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL frame_sync: col_o=%b never wrapped", col_o);
        end
    endtask

    task automatic hold(input logic [15:0] mask, input int frames);
        wait_frame_start();
        keys = mask;
        repeat (frames * FRAME - 2) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        logic [15:0] m;
        m = 16'd1 << code;
        hold(m, 2);
        hold(16'd0, 3);
    endtask

    task automatic bus_xfer(input logic [1:0] a, input logic we,
                            input logic [31:0] wd, output logic [31:0] rd);
        bit got;
        got = 0;
        rd = 32'hDEAD_BEEF;
        bus_addr_i = {28'd0, a, 2'd0};
        bus_we_i = we;
        bus_data_i = wd;
        bus_select_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus_ack_o) begin
                rd = bus_data_o;
                got = 1;
                break;
            end
        end
        bus_select_i = 1'b0;
        bus_we_i = 1'b0;
        if (!got) begin
            total++; bad++;
            $display("FAIL ack_timeout: addr=%0d no ack", a);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (col_o !== 4'b1110) begin
            bad++; $display("FAIL rst_col: got %b want 1110", col_o);
        end
        total++;
        if (bus_ack_o !== 1'b0 || bus_data_o !== 32'd0) begin
            bad++; $display("FAIL rst_bus: ack=%b data=%h want 0/0", bus_ack_o, bus_data_o);
        end
        total++;
        if (irq_o !== 1'b0) begin
            bad++; $display("FAIL rst_irq: got %b want 0", irq_o);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        bus_xfer(2'd1, 1'b0, 32'd0, rd);
        total++;
        if (rd !== 32'h0000_0020) begin
            bad++; $display("FAIL rst_status: got %h want 00000020", rd);
        end
    endtask

    task automatic test_single_press();
        logic [31:0] rd, ex;
        hold(16'h0200, 3);
        exp_q.push_back(4'h9);
        hold(16'd0, 3);
        total++;
        if (irq_o !== 1'b1) begin
            bad++; $display("FAIL press_irq: got %b want 1", irq_o);
        end
        bus_xfer(2'd1, 1'b0, 32'd0, rd);
        total++;
        if (rd !== 32'h0000_0001) begin
            bad++; $display("FAIL press_status: got %h want 00000001", rd);
        end
        bus_xfer(2'd0, 1'b0, 32'd0, rd);
        ex = model_pop();
        total++;
        if (rd !== ex || rd !== 32'h0000_0109) begin
            bad++; $display("FAIL press_data: got %h want %h", rd, ex);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (irq_o !== 1'b0) begin
            bad++; $display("FAIL press_irq_fall: got %b want 0", irq_o);
        end
    endtask

    task automatic test_short_press();
        logic [31:0] rd;
        hold(16'd1 << 5, 1);
        hold(16'd0, 2);
        bus_xfer(2'd1, 1'b0, 32'd0, rd);
        total++;
        if (rd !== 32'h0000_0020) begin
            bad++; $display("FAIL short_status: got %h want 00000020", rd);
        end
    endtask

    task automatic test_multi_hold();
        logic [31:0] rd, ex;
        hold(16'h0001, 1);
        hold(16'h0003, 5);
        bus_xfer(2'd1, 1'b0, 32'd0, rd);
        total++;
        if (rd !== 32'h0000_0020) begin
            bad++; $display("FAIL multi_nopush: got %h want 00000020", rd);
        end
        hold(16'h0001, 1);
        exp_q.push_back(4'h0);
        hold(16'd0, 3);
        bus_xfer(2'd1, 1'b0, 32'd0, rd);
        total++;
        if (rd !== 32'h0000_0001) begin
            bad++; $display("FAIL multi_status: got %h want 00000001", rd);
        end
        bus_xfer(2'd0, 1'b0, 32'd0, rd);
        ex = model_pop();
        total++;
        if (rd !== ex) begin
            bad++; $display("FAIL multi_data: got %h want %h", rd, ex);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd, ex;
        logic [3:0]  codes [5];
        codes = '{4'h3, 4'h6, 4'hA, 4'hF, 4'hC};
        for (int i = 0; i < 5; i++) begin
            press(codes[i]);
            if (i < 4) exp_q.push_back(codes[i]);
        end
        bus_xfer(2'd1, 1'b0, 32'd0, rd);
        total++;
        if (rd !== 32'h0000_00C4) begin
            bad++; $display("FAIL ovf_status: got %h want 000000C4", rd);
        end
        bus_xfer(2'd2, 1'b1, 32'h2, rd);
        bus_xfer(2'd1, 1'b0, 32'd0, rd);
        total++;
        if (rd !== 32'h0000_0044) begin
            bad++; $display("FAIL ovf_clear: got %h want 00000044", rd);
        end
        for (int i = 0; i < 5; i++) begin
            bus_xfer(2'd0, 1'b0, 32'd0, rd);
            ex = model_pop();
            total++;
            if (rd !== ex) begin
                bad++; $display("FAIL ovf_data%0d: got %h want %h", i, rd, ex);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ex;
        logic        ex_ack;
        press(4'h1);
        exp_q.push_back(4'h1);
        press(4'h2);
        exp_q.push_back(4'h2);
        bus_addr_i = 32'd0;
        bus_we_i = 1'b0;
        bus_select_i = 1'b1;
        for (int k = 2; k <= 7; k++) begin
            @(posedge clk); #1;
            ex_ack = (k % 2 == 0);
            ex = ex_ack ? model_pop() : 32'd0;
            total++;
            if (bus_ack_o !== ex_ack || bus_data_o !== ex) begin
                bad++;
                $display("FAIL b2b_cyc%0d: ack=%b data=%h want %b/%h",
                         k, bus_ack_o, bus_data_o, ex_ack, ex);
            end
        end
        bus_select_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midscan();
        logic [31:0] rd;
        bit          seen;
        press(4'h4);
        exp_q.push_back(4'h4);
        press(4'h7);
        exp_q.push_back(4'h7);
        press(4'h8);
        exp_q.push_back(4'h8);
        bus_xfer(2'd1, 1'b0, 32'd0, rd);
        total++;
        if (rd !== 32'h0000_0003) begin
            bad++; $display("FAIL rst3_status: got %h want 00000003", rd);
        end
        seen = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge clk); #1;
            if (col_o == 4'b1101) begin
                seen = 1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL rst3_col1: col_o=%b want 1101", col_o);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (col_o !== 4'b1110 || irq_o !== 1'b0 || bus_ack_o !== 1'b0) begin
            bad++;
            $display("FAIL rst3_async: col=%b irq=%b ack=%b want 1110/0/0",
                     col_o, irq_o, bus_ack_o);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        bus_xfer(2'd1, 1'b0, 32'd0, rd);
        total++;
        if (rd !== 32'h0000_0020) begin
            bad++; $display("FAIL rst3_empty: got %h want 00000020", rd);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_short_press();
        test_multi_hold();
        test_overflow();
        test_back_to_back();
        test_reset_midscan();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL sb_leftover: %0d entries want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
